regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor of the single-port-write register file.
- Generic data width, register count and read-port count.
- Write-to-read bypass in the same cycle.
- Per-register scoreboard (busy bits) that the pipelined datapath uses for hazard detection: decode marks a destination pending, writeback retires it.
- Sits between decode (read/issue) and writeback (write) in the pipelined core.

Parameters:
- DW, 64: data width of each register.
- NREG, 32: number of registers; must be a power of 2 and at least 2.
- AW, $clog2(NREG): address width (derived; do not override).
- NRD, 2: number of independent read ports.
- ZR, NREG-1: index of the hardwired zero register.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- we3  in  1  writeback write enable.
- wa3  in  AW  writeback address.
- wd3  in  DW  writeback data.
- ra  in  NRD*AW  read addresses, port i at bits [i*AW +: AW].
- rd  out  NRD*DW  read data, port i at bits [i*DW +: DW].
- rd_busy  out  NRD  port i source still pending (hazard).
- iss_en  in  1  issue: mark destination pending.
- iss_wa  in  AW  issued destination address.
- pend_cnt  out  AW+1  number of registers currently pending (registered).

Behaviour:
- Reset (reset_n low, asynchronous):
  - regs[k] = k zero-extended to DW for k != ZR; regs[ZR] = 0.
  - All busy bits = 0; pend_cnt = 0.
  - rd and rd_busy follow combinationally from these values.
  - Reset mid-operation discards all pending state; no write is committed in a cycle where reset_n is low.
- Write, sequential:
  - At posedge clk, if we3 == 1 and wa3 != ZR, then regs[wa3] <= wd3.
  - Writes to ZR are silently dropped; regs[ZR] stays 0 forever.
  - we3 = X/Z is treated as no write.
- Read, combinational, 0-cycle latency, port i:
  - If ra_i == ZR: rd_i = 0.
  - Else if we3 && wa3 == ra_i: rd_i = wd3 (bypass).
  - Else: rd_i = regs[ra_i].
  - All ports are independent; any ports may read the same address.
- Scoreboard, sequential, per register k != ZR:
  - set_k = iss_en && iss_wa == k.
  - clr_k = we3 && wa3 == k.
  - Next busy_k: set_k gives 1; else clr_k gives 0; else hold.
  - Simultaneous set and clear of the same register: set wins, because a new producer supersedes the retiring one.
  - Issue to an already-busy register (WAW) keeps it busy; there is no count per register.
  - Issue or write to ZR never affects busy state; busy[ZR] is always 0.
- rd_busy_i:
  - Equals busy[ra_i] && !(we3 && wa3 == ra_i).
  - A register written back this cycle is not reported busy, because its value is bypassed.
  - rd_busy_i = 0 when ra_i == ZR.
  - An issue in the same cycle does not affect rd_busy in that cycle; it affects the next cycle.
- pend_cnt:
  - Registered popcount of the busy vector after the update.
  - Range is 0..NREG-1, so it never overflows AW+1 bits.

Decomposition:
- Package regfile_pkg:
  - Defaults DW_DEF = 64, NREG_DEF = 32.
  - Function zr_idx(nreg) returning nreg-1.
  - Typedef reg_addr_t, logic [AW-1:0] for the default configuration.
- Sub-module rf_scoreboard, owning the busy vector, set/clear priority, rd_busy masking and pend_cnt.
- regfile_sb instantiates rf_scoreboard next to the storage array and bypass muxes.

Test Plan:
- Reset then read ra={5,31} with we3=0 -> rd={5,0}, rd_busy=00, pend_cnt=0.
- Write wa3=7, wd3=0xDEAD_BEEF with we3=1, ra={7,7}:
  - Same cycle: rd={0xDEADBEEF, 0xDEADBEEF} via bypass.
  - Next cycle with we3=0: still 0xDEADBEEF.
- Write wa3=31, wd3=0x1234 -> next cycle ra=31 reads 0; no busy change.
- Issue sequence:
  - iss_en with iss_wa=3 -> next cycle ra=3 gives rd_busy=1 and pend_cnt=1.
  - Cycle with we3=1, wa3=3, wd3=0x55 -> that cycle rd_busy=0 and rd=0x55; next cycle pend_cnt=0.
- Same-cycle iss_wa=4 and we3 to wa3=4 while reg 4 is busy -> next cycle busy[4]=1 (set wins), pend_cnt unchanged.
- Issue regs 1, 2 and 9 on consecutive cycles (pend_cnt=3), then pulse reset_n low between clock edges:
  - Immediately: pend_cnt=0, rd_busy=0, and reg 9 reads 9.
  - After release, a write in the same cycle as reset was not committed.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Other files pull these in with a package import.
package regfile_pkg;

    localparam int DW_DEF   = 64;
    localparam int NREG_DEF = 32;

    // The hardwired zero register is always the highest index.
    function automatic int zr_idx(input int nreg);
        return nreg - 1;
    endfunction

    typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for hazard detection: issue marks a register pending, writeback retires it.
// Also produces the per-port hazard flags and a registered count of pending registers.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2,
    parameter int ZR   = zr_idx(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     wa_i,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_wa_i,
    input  logic [NRD*AW-1:0] ra_i,
    output logic [NRD-1:0]    rd_busy_o,
    output logic [AW:0]       pend_cnt_o
);

    localparam logic [AW-1:0] ZR_A = AW'(ZR);

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     pend_q, pend_d;

    // A new producer supersedes the one retiring in the same cycle, so set beats clear.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NREG; k++) begin
            if (k != ZR) begin
                if (iss_en_i && (iss_wa_i == AW'(k))) begin
                    busy_d[k] = 1'b1;
                end else if (we_i && (wa_i == AW'(k))) begin
                    busy_d[k] = 1'b0;
                end
            end
        end
        busy_d[ZR] = 1'b0;
    end

    always_comb begin
        pend_d = '0;
        for (int k = 0; k < NREG; k++) begin
            pend_d = pend_d + (AW+1)'(busy_d[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    // A register being written back right now is bypassed, so it is not a hazard.
    for (genvar i = 0; i < NRD; i++) begin : g_busy
        logic [AW-1:0] ra_p;
        assign ra_p         = ra_i[i*AW +: AW];
        assign rd_busy_o[i] = (ra_p != ZR_A) && busy_q[ra_p] && !(we_i && (wa_i == ra_p));
    end

    assign pend_cnt_o = pend_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle write bypass and a hazard scoreboard.
// Sits between decode (reads, issue) and writeback (single write port).
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2,
    parameter int ZR   = zr_idx(NREG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we3,
    input  logic [AW-1:0]     wa3,
    input  logic [DW-1:0]     wd3,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    rd_busy,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_wa,
    output logic [AW:0]       pend_cnt
);

    localparam logic [AW-1:0] ZR_A = AW'(ZR);

    logic [DW-1:0] regs_q [NREG];

    // Reset loads each register with its own index, which makes early reads easy to recognise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= (k == ZR) ? '0 : DW'(k);
            end
        end else if (we3 && (wa3 != ZR_A)) begin
            regs_q[wa3] <= wd3;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra_p;
        logic [DW-1:0] rd_p;

        assign ra_p = ra[i*AW +: AW];

        always_comb begin
            if (ra_p == ZR_A) begin
                rd_p = '0;
            end else if (we3 && (wa3 == ra_p)) begin
                rd_p = wd3;
            end else begin
                rd_p = regs_q[ra_p];
            end
        end

        assign rd[i*DW +: DW] = rd_p;
    end

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .NRD  (NRD),
        .ZR   (ZR)
    ) u_sb (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .we_i       (we3),
        .wa_i       (wa3),
        .iss_en_i   (iss_en),
        .iss_wa_i   (iss_wa),
        .ra_i       (ra),
        .rd_busy_o  (rd_busy),
        .pend_cnt_o (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then randomized traffic,
// compared against an array/queue-level reference model.
module tb_regfile_sb;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         we3;
    logic [4:0]   wa3;
    logic [63:0]  wd3;
    logic [9:0]   ra;
    logic [127:0] rd;
    logic [1:0]   rd_busy;
    logic         iss_en;
    logic [4:0]   iss_wa;
    logic [5:0]   pend_cnt;

    int checks   = 0;
    int failures = 0;

    logic [63:0] m_regs [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .iss_en   (iss_en),
        .iss_wa   (iss_wa),
        .pend_cnt (pend_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 32; k++) begin
            m_regs[k] = (k == 31) ? 64'd0 : 64'(k);
            m_busy[k] = 1'b0;
        end
    endtask

    function automatic int m_pend();
        int n = 0;
        for (int k = 0; k < 32; k++) n += int'(m_busy[k]);
        return n;
    endfunction

    task automatic m_update();
        if (reset_n) begin
            if (we3 && wa3 != 5'd31) begin
                m_regs[wa3] = wd3;
                m_busy[wa3] = 1'b0;
            end
            if (iss_en && iss_wa != 5'd31) m_busy[iss_wa] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [4:0]  a;
        logic [63:0] e;
        bit          eb;
        for (int p = 0; p < 2; p++) begin
            a = ra[p*5 +: 5];
            if (a == 5'd31)                 e = 64'd0;
            else if (we3 && wa3 == a)       e = wd3;
            else                            e = m_regs[a];
            eb = (a != 5'd31) && m_busy[a] && !(we3 && wa3 == a);
            chk($sformatf("rd%0d", p), rd[p*64 +: 64], e);
            chk($sformatf("busy%0d", p), 64'(rd_busy[p]), 64'(eb));
        end
        chk("pend", 64'(pend_cnt), 64'(m_pend()));
    endtask

    task automatic drive(input bit we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input bit ie, input logic [4:0] iw);
        we3 = we; wa3 = wa; wd3 = wd;
        ra = {r1, r0};
        iss_en = ie; iss_wa = iw;
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) return 5'd31;
        return 5'($urandom_range(0, 3));
    endfunction

    initial begin
        reset_n = 1'b0;
        we3 = 1'b0; wa3 = '0; wd3 = '0; ra = '0; iss_en = 1'b0; iss_wa = '0;
        m_reset();
        #12;
        ra = {5'd31, 5'd5};
        #1;
        chk("rst_rd0", rd[63:0], 64'd5);
        chk("rst_rd1", rd[127:64], 64'd0);
        chk("rst_busy", 64'(rd_busy), 64'd0);
        chk("rst_pend", 64'(pend_cnt), 64'd0);
        reset_n = 1'b1;
        tick();

        drive(1, 5'd7, 64'hDEAD_BEEF, 5'd7, 5'd7, 0, 0);
        check_all();
        chk("bypass", rd[63:0], 64'hDEAD_BEEF);
        tick();
        drive(0, 5'd0, 64'd0, 5'd7, 5'd7, 0, 0);
        check_all();
        chk("hold7", rd[127:64], 64'hDEAD_BEEF);
        tick();

        drive(1, 5'd31, 64'h1234, 5'd31, 5'd31, 0, 0);
        check_all();
        tick();
        drive(0, 5'd0, 64'd0, 5'd31, 5'd31, 0, 0);
        check_all();
        chk("zr_read", rd[63:0], 64'd0);
        chk("zr_pend", 64'(pend_cnt), 64'd0);
        tick();

        drive(0, 5'd0, 64'd0, 5'd3, 5'd3, 1, 5'd3);
        check_all();
        chk("iss_same_cyc", 64'(rd_busy[0]), 64'd0);
        tick();
        drive(0, 5'd0, 64'd0, 5'd3, 5'd3, 0, 0);
        check_all();
        chk("busy3", 64'(rd_busy[0]), 64'd1);
        chk("pend1", 64'(pend_cnt), 64'd1);
        tick();
        drive(1, 5'd3, 64'h55, 5'd3, 5'd3, 0, 0);
        check_all();
        chk("busy3_wb", 64'(rd_busy[0]), 64'd0);
        chk("rd55", rd[63:0], 64'h55);
        tick();
        drive(0, 5'd0, 64'd0, 5'd3, 5'd3, 0, 0);
        check_all();
        chk("pend0", 64'(pend_cnt), 64'd0);
        tick();

        drive(0, 5'd0, 64'd0, 5'd4, 5'd4, 1, 5'd4);
        tick();
        drive(1, 5'd4, 64'h99, 5'd4, 5'd4, 1, 5'd4);
        check_all();
        tick();
        drive(0, 5'd0, 64'd0, 5'd4, 5'd4, 0, 0);
        check_all();
        chk("set_wins", 64'(rd_busy[0]), 64'd1);
        chk("pend_keep", 64'(pend_cnt), 64'd1);
        tick();
        drive(1, 5'd4, 64'h44, 5'd0, 5'd0, 0, 0);
        tick();

        drive(0, 5'd0, 64'd0, 5'd9, 5'd9, 1, 5'd1);
        tick();
        drive(0, 5'd0, 64'd0, 5'd9, 5'd9, 1, 5'd2);
        tick();
        drive(0, 5'd0, 64'd0, 5'd9, 5'd9, 1, 5'd9);
        tick();
        drive(1, 5'd10, 64'hAAAA, 5'd9, 5'd9, 0, 0);
        check_all();
        chk("pend3", 64'(pend_cnt), 64'd3);
        reset_n = 1'b0;
        #1;
        m_reset();
        chk("arst_pend", 64'(pend_cnt), 64'd0);
        chk("arst_busy", 64'(rd_busy), 64'd0);
        chk("arst_rd9", rd[63:0], 64'd9);
        tick();
        #2;
        reset_n = 1'b1;
        drive(0, 5'd0, 64'd0, 5'd10, 5'd10, 0, 0);
        chk("no_commit", rd[63:0], 64'd10);
        check_all();
        tick();

        for (int n = 0; n < 400; n++) begin
            drive(bit'($urandom_range(0, 1)), rnd_addr(), {$urandom, $urandom},
                  rnd_addr(), rnd_addr(), bit'($urandom_range(0, 1)), rnd_addr());
            check_all();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
